// File: rtl/input_job_scheduler.sv
// Round-robin job scheduler: grants one of two requesters per whole job and
// forwards its beats to the hash input stream with a delimiter and a completion report.
module input_job_scheduler #(
    parameter int ISSUE_BYTES = 16,
    parameter int LEN_WIDTH   = 24,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   job_valid,
    output logic [1:0]                   job_ready,
    input  logic [2*LEN_WIDTH-1:0]       job_len,
    input  logic [1:0]                   src_valid,
    output logic [1:0]                   src_ready,
    input  logic [2*ISSUE_BYTES*8-1:0]   src_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_delim,
    output logic [ISSUE_BYTES*8-1:0]     out_data,
    output logic                         done_valid,
    input  logic                         done_ready,
    output logic                         done_src,
    output logic [ADDR_WIDTH-1:0]        done_base_addr,
    output logic [LEN_WIDTH-1:0]         done_beats
);
    localparam int DATA_W = ISSUE_BYTES * 8;
    localparam int SHIFT  = $clog2(ISSUE_BYTES);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] head_addr_q, head_addr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  beats_total_q, beats_total_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;

    logic                  pick;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [LEN_WIDTH:0]    len_round;
    logic [LEN_WIDTH-1:0]  new_beats;
    logic                  out_fire;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick      = job_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        sel_len   = pick ? job_len[2*LEN_WIDTH-1:LEN_WIDTH] : job_len[LEN_WIDTH-1:0];
        // One extra bit keeps the round-up of the largest length from wrapping.
        len_round = {1'b0, sel_len} + (LEN_WIDTH+1)'(ISSUE_BYTES - 1);
        new_beats = LEN_WIDTH'(len_round >> SHIFT);

        job_ready = '0;
        src_ready = '0;
        out_valid = 1'b0;
        out_delim = 1'b0;
        out_data  = grant_q ? src_data[2*DATA_W-1:DATA_W] : src_data[DATA_W-1:0];
        if (state_q == IDLE && |job_valid) begin
            job_ready[pick] = 1'b1;
        end
        if (state_q == STREAM) begin
            out_valid          = src_valid[grant_q];
            src_ready[grant_q] = out_ready;
            out_delim          = (remaining_q == LEN_WIDTH'(1));
        end
        out_fire = out_valid && out_ready;

        done_valid     = (state_q == DONE);
        done_src       = grant_q;
        done_base_addr = base_q;
        done_beats     = beats_total_q;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        head_addr_d   = head_addr_q;
        base_d        = base_q;
        beats_total_d = beats_total_q;
        remaining_d   = remaining_q;
        case (state_q)
            IDLE: begin
                if (|job_valid) begin
                    grant_d       = pick;
                    base_d        = head_addr_q;
                    beats_total_d = new_beats;
                    remaining_d   = new_beats;
                    state_d       = (new_beats == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (out_fire) begin
                    head_addr_d = head_addr_q + ADDR_WIDTH'(ISSUE_BYTES);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (done_ready) begin
                    rr_ptr_d = ~grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, so it is tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            rr_ptr_q      <= 1'b0;
            head_addr_q   <= '0;
            base_q        <= '0;
            beats_total_q <= '0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            head_addr_q   <= head_addr_d;
            base_q        <= base_d;
            beats_total_q <= beats_total_d;
            remaining_q   <= remaining_d;
        end
    end

endmodule

// File: tb/tb_input_job_scheduler.sv
// Randomized bench for input_job_scheduler: a job-level reference model checks
// every cycle, and directed scenarios pin the model with literal expectations.
module tb_input_job_scheduler;
    localparam int IB = 16;
    localparam int LW = 24;
    localparam int AW = 32;
    localparam int DW = IB * 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        job_valid;
    logic [1:0]        job_ready;
    logic [2*LW-1:0]   job_len;
    logic [1:0]        src_valid;
    logic [1:0]        src_ready;
    logic [2*DW-1:0]   src_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_delim;
    logic [DW-1:0]     out_data;
    logic              done_valid;
    logic              done_ready;
    logic              done_src;
    logic [AW-1:0]     done_base_addr;
    logic [LW-1:0]     done_beats;

    always #5 clk = ~clk;

    input_job_scheduler #(.ISSUE_BYTES(IB), .LEN_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_delim(out_delim), .out_data(out_data),
        .done_valid(done_valid), .done_ready(done_ready), .done_src(done_src),
        .done_base_addr(done_base_addr), .done_beats(done_beats)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus driver ----------------
    int unsigned req_q0[$];
    int unsigned req_q1[$];
    int p_sv = 100, p_or = 100, p_dr = 100;

    task automatic push_req(input int src, input int unsigned len);
        if (src == 0) req_q0.push_back(len);
        else          req_q1.push_back(len);
    endtask

    function automatic int unsigned pick_len();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return 16;
            3:       return 17;
            4:       return $urandom_range(2, 120);
            default: return 32;
        endcase
    endfunction

    initial begin
        logic [1:0] acc_s;
        logic [1:0] beat_s;
        job_valid  = '0;
        job_len    = '0;
        src_valid  = '0;
        src_data   = '0;
        out_ready  = 1'b0;
        done_ready = 1'b0;
        forever begin
            @(negedge clk);
            acc_s  = rst ? 2'b00 : (job_valid & job_ready);
            beat_s = src_valid & src_ready;
            @(posedge clk);
            #1;
            if (acc_s[0]) req_q0.delete(0);
            if (acc_s[1]) req_q1.delete(0);
            job_valid[0]       = (req_q0.size() != 0);
            job_valid[1]       = (req_q1.size() != 0);
            job_len[LW-1:0]    = (req_q0.size() != 0) ? LW'(req_q0[0]) : '0;
            job_len[2*LW-1:LW] = (req_q1.size() != 0) ? LW'(req_q1[0]) : '0;
            for (int i = 0; i < 2; i++) begin
                if (!src_valid[i] || beat_s[i]) begin
                    src_valid[i]        = int'($urandom_range(0, 99)) < p_sv;
                    src_data[i*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
            end
            out_ready  = int'($urandom_range(0, 99)) < p_or;
            done_ready = int'($urandom_range(0, 99)) < p_dr;
        end
    end

    // ---------------- reference model, compare and logging ----------------
    bit          m_stream, m_report, m_src, m_rr;
    logic [AW-1:0] m_head, m_base;
    int          m_total, m_left;

    int          out_beats = 0, delims = 0, done_total = 0;
    logic        done_src_log[$];
    logic [AW-1:0] done_base_log[$];
    logic [LW-1:0] done_beats_log[$];

    always @(negedge clk) begin
        logic [1:0]    exp_jr, exp_sr;
        logic          exp_ov, exp_delim, g;
        logic [DW-1:0] exp_data;
        logic [LW-1:0] g_len;
        if (rst) begin
            m_stream = 0; m_report = 0; m_src = 0; m_rr = 0;
            m_head = '0; m_base = '0; m_total = 0; m_left = 0;
        end else begin
            exp_jr = '0; exp_sr = '0; exp_ov = 1'b0; exp_delim = 1'b0;
            g      = job_valid[m_rr] ? m_rr : ~m_rr;
            g_len  = g ? job_len[2*LW-1:LW] : job_len[LW-1:0];
            if (!m_stream && !m_report && job_valid != 2'b00) exp_jr[g] = 1'b1;
            exp_data = m_src ? src_data[2*DW-1:DW] : src_data[DW-1:0];
            if (m_stream) begin
                exp_ov         = src_valid[m_src];
                exp_sr[m_src]  = out_ready;
                exp_delim      = (m_left == 1);
            end
            check("job_ready", job_ready, exp_jr);
            check("src_ready", src_ready, exp_sr);
            check("out_valid", out_valid, exp_ov);
            check("out_delim", out_delim, exp_delim);
            check("done_valid", done_valid, m_report);
            if (exp_ov) check("out_data", out_data, exp_data);
            if (m_report) begin
                check("done_src", done_src, m_src);
                check("done_base_addr", done_base_addr, m_base);
                check("done_beats", done_beats, LW'(m_total));
            end

            if (out_valid && out_ready) begin
                out_beats++;
                if (out_delim) delims++;
            end
            if (done_valid && done_ready) begin
                done_total++;
                done_src_log.push_back(done_src);
                done_base_log.push_back(done_base_addr);
                done_beats_log.push_back(done_beats);
            end

            if (!m_stream && !m_report) begin
                if (job_valid != 2'b00) begin
                    m_src   = g;
                    m_base  = m_head;
                    m_total = (int'(g_len) + IB - 1) / IB;
                    m_left  = m_total;
                    if (m_total == 0) m_report = 1;
                    else              m_stream = 1;
                end
            end else if (m_stream) begin
                if (src_valid[m_src] && out_ready) begin
                    m_head = m_head + AW'(IB);
                    m_left--;
                    if (m_left == 0) begin
                        m_stream = 0;
                        m_report = 1;
                    end
                end
            end else if (done_ready) begin
                m_rr     = ~m_src;
                m_report = 0;
            end
        end
    end

    // ---------------- directed + random scenarios ----------------
    task automatic wait_dones(input int target, input int budget, input string name);
        int n = 0;
        while (done_total < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, done_total, target);
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        int n = 0;
        while (out_beats < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, out_beats, target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int b, ob0, dl0, n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_job_ready", job_ready, 2'b00);
        check("reset_src_ready", src_ready, 2'b00);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_delim", out_delim, 1'b0);
        check("reset_done_valid", done_valid, 1'b0);

        // Single 40-byte job on src0.
        b = done_total; ob0 = out_beats; dl0 = delims;
        push_req(0, 40);
        wait_dones(b + 1, 200, "t1_done_count");
        check("t1_src", done_src_log[b], 1'b0);
        check("t1_base", done_base_log[b], 0);
        check("t1_beats", done_beats_log[b], 3);
        check("t1_out_beats", out_beats - ob0, 3);
        check("t1_delims", delims - dl0, 1);

        // Zero-length job on src1 reports the current head (48).
        b = done_total; ob0 = out_beats; dl0 = delims;
        push_req(1, 0);
        wait_dones(b + 1, 200, "t4_done_count");
        check("t4_src", done_src_log[b], 1'b1);
        check("t4_base", done_base_log[b], 48);
        check("t4_beats", done_beats_log[b], 0);
        check("t4_no_beats", out_beats - ob0, 0);
        check("t4_no_delim", delims - dl0, 0);

        // Simultaneous requests after reset: src0 then src1.
        do_reset();
        b = done_total; dl0 = delims;
        push_req(0, 16);
        push_req(1, 16);
        wait_dones(b + 2, 200, "t2_done_count");
        check("t2_first_src", done_src_log[b], 1'b0);
        check("t2_first_base", done_base_log[b], 0);
        check("t2_second_src", done_src_log[b+1], 1'b1);
        check("t2_second_base", done_base_log[b+1], 16);
        check("t2_delims", delims - dl0, 2);

        // Backpressure on a 5-beat job with the other source also waiting.
        p_sv = 60; p_or = 50; p_dr = 50;
        b = done_total;
        push_req(0, 80);
        push_req(1, 33);
        wait_dones(b + 2, 600, "t3_done_count");
        check("t3_src", done_src_log[b], 1'b0);
        check("t3_base", done_base_log[b], 32);
        check("t3_beats", done_beats_log[b], 5);
        check("t3_other_base", done_base_log[b+1], 112);
        check("t3_other_beats", done_beats_log[b+1], 3);

        // done_ready held low while src0 has a pending descriptor.
        p_sv = 100; p_or = 100; p_dr = 0;
        b = done_total;
        push_req(1, 32);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_valid && n < 200);
        check("t5_reach_done", done_valid, 1'b1);
        push_req(0, 16);
        repeat (10) begin
            @(negedge clk);
            check("t5_job_ready_hold", job_ready, 2'b00);
        end
        p_dr = 100;
        wait_dones(b + 2, 200, "t5_done_count");
        check("t5_base_a", done_base_log[b], 160);
        check("t5_base_b", done_base_log[b+1], 192);

        // Reset in the middle of a 4-beat job.
        do_reset();
        b = done_total; ob0 = out_beats;
        push_req(0, 64);
        wait_beats(ob0 + 2, 200, "t6_two_beats");
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("t6_job_ready", job_ready, 2'b00);
        check("t6_src_ready", src_ready, 2'b00);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_out_delim", out_delim, 1'b0);
        check("t6_done_valid", done_valid, 1'b0);
        repeat (5) @(posedge clk);
        check("t6_no_done", done_total, b);
        push_req(1, 16);
        wait_dones(b + 1, 200, "t6_done_count");
        check("t6_new_base", done_base_log[b], 0);
        check("t6_new_src", done_src_log[b], 1'b1);

        // Maximum length: must stream, not collapse to a zero-beat job.
        b = done_total; ob0 = out_beats;
        push_req(0, 24'hFFFFFF);
        wait_beats(ob0 + 5, 200, "t7_streaming");
        check("t7_no_done", done_total, b);
        do_reset();

        // Random traffic from both sources.
        p_sv = 75; p_or = 70; p_dr = 60;
        b = done_total;
        for (int i = 0; i < 40; i++) push_req(int'($urandom_range(0, 1)), pick_len());
        wait_dones(b + 40, 8000, "rand_burst_done");
        b = done_total;
        for (int i = 0; i < 20; i++) begin
            push_req(int'($urandom_range(0, 1)), pick_len());
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        wait_dones(b + 20, 8000, "rand_trickle_done");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
